// File: rtl/rmii_rx_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : rmii_rx_framer_if
// Description : PHY-side dibit inputs and byte-stream outputs of the RMII
//               receive framer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rmii_rx_framer_if;
  logic [1:0]  i_rxd;
  logic        i_crs_dv;
  logic        i_rx_er;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        o_rx_sof;
  logic        o_rx_eof;
  logic [10:0] o_rx_len;
  logic        o_rx_crc_ok;
  logic        o_rx_err;

  modport slave (
    input  i_rxd, i_crs_dv, i_rx_er,
    output o_rx_data, o_rx_valid, o_rx_sof, o_rx_eof, o_rx_len, o_rx_crc_ok, o_rx_err
  );

  modport master (
    output i_rxd, i_crs_dv, i_rx_er,
    input  o_rx_data, o_rx_valid, o_rx_sof, o_rx_eof, o_rx_len, o_rx_crc_ok, o_rx_err
  );
endinterface
`default_nettype wire

// File: rtl/rmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : rmii_rx_framer
// Description : 100 Mb/s RMII receive framer; strips preamble/SFD, emits bytes
//               with sof/eof markers, length, FCS check and error status.
// Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx_framer #(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64
) (
  input  wire logic       clk_rmii,
  input  wire logic       rst_ni,
  rmii_rx_framer_if.slave io_rmii
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] c_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] c_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] c_MAX_LEN     = 11'(MAX_LEN);
  localparam logic [10:0] c_MIN_LEN     = 11'(MIN_LEN);
  localparam logic [10:0] c_BCNT_SAT    = 11'h7FF;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  w_rxd;
  logic        w_dv;
  logic        w_er;
  logic        w_start;
  logic        w_take;
  logic        w_done;
  logic        w_ovf;
  logic        w_term;
  logic        w_align;
  logic [31:0] w_crc_nxt;
  logic [7:0]  w_byte;

  logic [7:0]  r_shift;
  logic [1:0]  r_dcnt;
  logic [10:0] r_bcnt;
  logic [31:0] r_crc;
  logic [31:0] r_crc_byte;
  logic [7:0]  r_hold;
  logic        r_hold_vld;
  logic        r_sof_pend;
  logic        r_er;
  logic        r_dv_low;

  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_sof;
  logic        r_eof;
  logic [10:0] r_len;
  logic        r_crc_ok;
  logic        r_err;

  // Reflected CRC-32 advanced by one dibit; bit 0 is the earlier wire bit.
  function automatic logic [31:0] f_crc_step(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = {1'b0, c[31:1]} ^ ((c[0] ^ dibit[i]) ? c_CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  assign w_rxd     = io_rmii.i_rxd;
  assign w_dv      = io_rmii.i_crs_dv;
  assign w_er      = io_rmii.i_rx_er;
  assign w_crc_nxt = f_crc_step(r_crc, w_rxd);
  assign w_byte    = {w_rxd, r_shift[7:2]};

  always_ff @(posedge clk_rmii or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_ovf       = 1'b0;
    w_term      = 1'b0;
    w_align     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dv) begin
          if (w_rxd == 2'b01) begin
            w_state_nxt = S_PREAMBLE;
          end else if (w_rxd != 2'b00) begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!w_dv) begin
          w_state_nxt = S_IDLE;
        end else if (w_rxd == 2'b11) begin
          w_state_nxt = S_DATA;
          w_start     = 1'b1;
        end else if (w_rxd != 2'b01) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DATA: begin
        // A single low crs_dv mid-byte is the PHY's end-of-frame CRS toggle.
        if (!w_dv && (r_dcnt == 2'd0)) begin
          w_term      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_dv && r_dv_low) begin
          w_term      = 1'b1;
          w_align     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_take = 1'b1;
          if (r_dcnt == 2'd3) begin
            w_done = 1'b1;
            if (r_bcnt == c_MAX_LEN) begin
              w_ovf       = 1'b1;
              w_state_nxt = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (!w_dv && r_dv_low) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_rmii or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift    <= 8'h00;
      r_dcnt     <= 2'd0;
      r_bcnt     <= 11'd0;
      r_crc      <= c_CRC_INIT;
      r_crc_byte <= c_CRC_INIT;
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
      r_sof_pend <= 1'b0;
      r_er       <= 1'b0;
      r_dv_low   <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_len      <= 11'd0;
      r_crc_ok   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_dv_low <= !w_dv;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
      if (w_start) begin
        r_dcnt     <= 2'd0;
        r_bcnt     <= 11'd0;
        r_er       <= 1'b0;
        r_crc      <= c_CRC_INIT;
        r_hold_vld <= 1'b0;
        r_sof_pend <= 1'b1;
      end
      if (w_take) begin
        r_shift <= w_byte;
        r_crc   <= w_crc_nxt;
        r_dcnt  <= r_dcnt + 2'd1;
        r_er    <= r_er | w_er;
      end
      if (w_done) begin
        r_hold     <= w_byte;
        r_hold_vld <= 1'b1;
        r_crc_byte <= w_crc_nxt;
        if (r_bcnt != c_BCNT_SAT) begin
          r_bcnt <= r_bcnt + 11'd1;
        end
      end
      // The held byte goes out one byte late so the last one can carry eof.
      if ((w_done || w_term) && r_hold_vld) begin
        r_valid    <= 1'b1;
        r_data     <= r_hold;
        r_sof      <= r_sof_pend;
        r_sof_pend <= 1'b0;
      end
      if (w_ovf) begin
        r_eof      <= 1'b1;
        r_len      <= c_MAX_LEN;
        r_crc_ok   <= (r_crc_byte == c_CRC_RESIDUE);
        r_err      <= 1'b1;
        r_hold_vld <= 1'b0;
      end
      if (w_term) begin
        r_hold_vld <= 1'b0;
        if (r_hold_vld) begin
          r_eof    <= 1'b1;
          r_len    <= r_bcnt;
          r_crc_ok <= (r_crc_byte == c_CRC_RESIDUE);
          r_err    <= r_er | w_align | (r_bcnt < c_MIN_LEN);
        end
      end
    end
  end

  assign io_rmii.o_rx_data   = r_data;
  assign io_rmii.o_rx_valid  = r_valid;
  assign io_rmii.o_rx_sof    = r_sof;
  assign io_rmii.o_rx_eof    = r_eof;
  assign io_rmii.o_rx_len    = r_len;
  assign io_rmii.o_rx_crc_ok = r_crc_ok;
  assign io_rmii.o_rx_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmii_rx_framer
// Description : Randomised frame stimulus with a queue-based scoreboard for
//               the RMII receive framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_framer;
  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  logic clk_rmii = 1'b0;
  logic rst_ni   = 1'b0;

  always #10 clk_rmii = ~clk_rmii;

  rmii_rx_framer_if u_if ();

  rmii_rx_framer #(
    .MAX_LEN(MAX_LEN),
    .MIN_LEN(MIN_LEN)
  ) u_dut (
    .clk_rmii(clk_rmii),
    .rst_ni  (rst_ni),
    .io_rmii (u_if.slave)
  );

  typedef struct {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic [10:0] len;
    logic        crc_ok;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] frame[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Standard Ethernet CRC-32 of frame[0..n-1] (reflected, inverted result).
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // True when the last four of the first n bytes are the FCS of the rest.
  function automatic logic fcs_ok(input int n);
    if (n < 4) return 1'b0;
    return crc32(n - 4) == {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
  endfunction

  function automatic void make_frame(input int n);
    logic [31:0] c;
    frame.delete();
    for (int i = 0; i < n - 4; i++) frame.push_back(8'($urandom));
    c = crc32(n - 4);
    frame.push_back(c[7:0]);
    frame.push_back(c[15:8]);
    frame.push_back(c[23:16]);
    frame.push_back(c[31:24]);
  endfunction

  function automatic void push_expect(input int n_wire, input logic er, input logic align);
    int   n;
    logic ok;
    logic err;
    exp_t e;
    n   = (n_wire > MAX_LEN) ? MAX_LEN : n_wire;
    ok  = fcs_ok(n);
    err = (n_wire > MAX_LEN) || er || align || (n < MIN_LEN);
    for (int i = 0; i < n; i++) begin
      e.d      = frame[i];
      e.sof    = (i == 0);
      e.eof    = (i == n - 1);
      e.len    = 11'(n);
      e.crc_ok = ok;
      e.err    = err;
      sb_q.push_back(e);
    end
  endfunction

  task automatic dibit(input logic [1:0] d, input logic dv, input logic er);
    @(negedge clk_rmii);
    u_if.i_rxd    = d;
    u_if.i_crs_dv = dv;
    u_if.i_rx_er  = er;
  endtask

  task automatic idle_gap();
    repeat (2 + $urandom_range(2)) dibit(2'b00, 1'b0, 1'b0);
  endtask

  task automatic preamble();
    repeat (15) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b11, 1'b1, 1'b0);
  endtask

  // end_mode: 0 clean, 1 crs_dv toggling on odd dibits of the last byte,
  // 2 one trailing dibit (misaligned end).
  task automatic send_frame(input int er_idx, input int end_mode);
    logic [7:0] b;
    logic       dv;
    preamble();
    for (int i = 0; i < frame.size(); i++) begin
      b = frame[i];
      for (int k = 0; k < 4; k++) begin
        dv = !((end_mode == 1) && (i == frame.size() - 1) && (k % 2 == 1));
        dibit(b[2*k +: 2], dv, (i == er_idx) && (k == 0));
      end
    end
    if (end_mode == 2) dibit(2'($urandom), 1'b1, 1'b0);
    idle_gap();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},  32'(u_if.o_rx_valid),  32'd0);
    check({tag, "_data"},   32'(u_if.o_rx_data),   32'd0);
    check({tag, "_sof"},    32'(u_if.o_rx_sof),    32'd0);
    check({tag, "_eof"},    32'(u_if.o_rx_eof),    32'd0);
    check({tag, "_len"},    32'(u_if.o_rx_len),    32'd0);
    check({tag, "_crc_ok"}, 32'(u_if.o_rx_crc_ok), 32'd0);
    check({tag, "_err"},    32'(u_if.o_rx_err),    32'd0);
  endtask

  always @(negedge clk_rmii) begin
    exp_t e;
    if (rst_ni && (u_if.o_rx_valid === 1'b1)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte got data %0h eof %0b expected no byte",
                 u_if.o_rx_data, u_if.o_rx_eof);
      end else begin
        e = sb_q.pop_front();
        check("rx_data", 32'(u_if.o_rx_data), 32'(e.d));
        check("rx_sof",  32'(u_if.o_rx_sof),  32'(e.sof));
        check("rx_eof",  32'(u_if.o_rx_eof),  32'(e.eof));
        if (e.eof) begin
          check("rx_len",    32'(u_if.o_rx_len),    32'(e.len));
          check("rx_crc_ok", 32'(u_if.o_rx_crc_ok), 32'(e.crc_ok));
          check("rx_err",    32'(u_if.o_rx_err),    32'(e.err));
        end
      end
    end
  end

  initial begin
    #4000000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [7:0] b;
    int         n;
    u_if.i_rxd    = 2'b00;
    u_if.i_crs_dv = 1'b0;
    u_if.i_rx_er  = 1'b0;
    rst_ni        = 1'b0;
    repeat (3) @(negedge clk_rmii);
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    repeat (3) dibit(2'b00, 1'b0, 1'b0);

    // Legal minimum-size frame.
    make_frame(64); push_expect(64, 1'b0, 1'b0); send_frame(-1, 0);

    // Corrupted payload byte.
    make_frame(64);
    frame[20] = frame[20] ^ (8'd1 << $urandom_range(7));
    push_expect(64, 1'b0, 1'b0); send_frame(-1, 0);

    // PHY receive error mid-frame.
    make_frame(64); push_expect(64, 1'b1, 1'b0); send_frame(30, 0);

    // Runt with valid FCS.
    make_frame(60); push_expect(60, 1'b0, 1'b0); send_frame(-1, 0);

    // Over-length, then a legal frame.
    make_frame(1530); push_expect(1530, 1'b0, 1'b0); send_frame(-1, 0);
    n = 64 + $urandom_range(200);
    make_frame(n); push_expect(n, 1'b0, 1'b0); send_frame(-1, 0);

    // crs_dv toggling on the last byte.
    make_frame(100); push_expect(100, 1'b0, 1'b0); send_frame(-1, 1);

    // Misaligned end.
    make_frame(80); push_expect(80, 1'b0, 1'b1); send_frame(-1, 2);

    // Preamble containing an illegal dibit: nothing may come out.
    repeat (5) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b10, 1'b1, 1'b0);
    repeat (9) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b11, 1'b1, 1'b0);
    repeat (80) dibit(2'($urandom), 1'b1, 1'b0);
    idle_gap();

    // Reset during byte 10: bytes 0..8 have left, no eof.
    make_frame(64);
    for (int i = 0; i < 9; i++) begin
      e.d = frame[i]; e.sof = (i == 0); e.eof = 1'b0;
      e.len = 11'd0; e.crc_ok = 1'b0; e.err = 1'b0;
      sb_q.push_back(e);
    end
    preamble();
    for (int i = 0; i < 10; i++) begin
      b = frame[i];
      for (int k = 0; k < 4; k++) dibit(b[2*k +: 2], 1'b1, 1'b0);
    end
    b = frame[10];
    dibit(b[1:0], 1'b1, 1'b0);
    dibit(b[3:2], 1'b1, 1'b0);
    @(negedge clk_rmii);
    rst_ni        = 1'b0;
    u_if.i_crs_dv = 1'b0;
    u_if.i_rxd    = 2'b00;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (2) @(negedge clk_rmii);
    rst_ni = 1'b1;
    repeat (2) dibit(2'b00, 1'b0, 1'b0);
    check("reset_drained", 32'(sb_q.size()), 32'd0);
    make_frame(72); push_expect(72, 1'b0, 1'b0); send_frame(-1, 0);

    // Random frames.
    for (int f = 0; f < 5; f++) begin
      int er_idx;
      int mode;
      n = 64 + $urandom_range(192);
      make_frame(n);
      if ($urandom_range(1) == 1) frame[$urandom_range(n - 1)] ^= 8'h10;
      er_idx = ($urandom_range(3) == 0) ? $urandom_range(n - 1) : -1;
      mode   = $urandom_range(2);
      push_expect(n, er_idx >= 0, mode == 2);
      send_frame(er_idx, mode);
    end

    repeat (20) dibit(2'b00, 1'b0, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
